rv_branch_predictor: RTL
========================

Name: rv_branch_predictor

Overview:
- Parametrised branch target buffer with 2-bit saturating direction counters for the 5-stage RV32I pipeline.
- Lookup is combinational in IF from the current PC. Update comes from ID, where Branch/Jump are resolved.
- Removes the fixed one-cycle flush on correctly predicted taken branches and jumps, which the current pipeline lacks.

Parameters:
- ENTRIES, 64: table depth; power of 2, 4..1024. IDX_W = log2(ENTRIES).
- TAG_W, 8: tag bits stored per entry, taken from PC[TAG_W+IDX_W+1 : IDX_W+2].
- HIST_W, 6: global history length, used only with the optional feature; HIST_W <= IDX_W.
- PERF_W, 32: width of the performance counters.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- PC_if  in  32  fetch PC
- pred_taken  out  1  predict taken (redirect fetch)
- pred_target  out  32  predicted next PC; valid only when pred_taken=1
- pred_hist  out  HIST_W  history snapshot to carry down the pipe (zero when feature absent)
- update_en  in  1  one resolved control-transfer instruction in ID this cycle
- update_pc  in  32  PC of the resolved instruction
- update_taken  in  1  actual outcome
- update_jump  in  1  1 = JAL/JALR, 0 = conditional branch
- update_target  in  32  actual target address
- update_hist  in  HIST_W  pred_hist carried with the instruction
- update_mispredict  in  1  prediction was wrong (direction or target)
- perf_lookups  out  PERF_W  count of update_en pulses
- perf_mispredicts  out  PERF_W  count of update_en pulses with update_mispredict=1

Behaviour:
- Entry contents: valid, tag[TAG_W], jump, ctr[1:0], target[31:2]. Target bits [1:0] are always 00.
- Index: idx = PC[IDX_W+1:2]. Tag: PC[TAG_W+IDX_W+1:IDX_W+2].
- Lookup (combinational, 0 latency):
  - hit = valid && tag match.
  - pred_taken = hit && (jump || ctr[1]).
  - pred_target = {target, 2'b00}.
  - On a miss, pred_taken=0 and pred_target=PC_if+4.
- Update is applied at the clk edge; effects are visible to lookup the next cycle.
  - Same-cycle lookup of the entry being updated returns the old contents.
- Update on a hit:
  - Conditional branch: ctr saturates at 11 on taken and at 00 on not-taken.
  - Jump: ctr forced to 11.
  - target is overwritten when update_taken=1.
  - jump flag is rewritten.
- Update on a miss:
  - update_taken=1 allocates the entry (replaces the previous occupant): valid=1, new tag, target, jump; ctr=10 (weakly taken), or 11 for a jump.
  - update_taken=0 leaves the table unchanged.
- Perf counters:
  - Increment on update_en; perf_mispredicts additionally requires update_mispredict.
  - Both saturate at all-ones and do not wrap.
- Reset:
  - All valid bits, all ctr values (to 01), perf counters and the history register clear in one cycle.
  - After reset, pred_taken=0 and pred_target=PC_if+4.
  - reset asserted together with update_en: reset wins and the update is dropped.
- update_en with update_pc bits [1:0] != 0 is ignored; perf counters still count it.

Optional Feature:
- Macro: RV_BP_GSHARE_EN.
- Defined:
  - A HIST_W-bit global history register (GHR) shifts in update_taken on each conditional-branch update; jumps do not shift it.
  - Direction-counter index = idx XOR {zeros, GHR} at lookup.
  - At update, the counter is indexed with update_hist instead of GHR.
  - pred_hist = GHR.
  - Tag, target and valid remain indexed by the plain idx, so the counters move to a separate ENTRIES-deep array.
- Undefined:
  - No GHR; the counters live in the entry; pred_hist = 0; update_hist is ignored.

Decomposition:
- Package rv_bp_pkg holds:
  - the entry struct;
  - counter encodings SNT=00, WNT=01, WT=10, ST=11;
  - the saturating-increment/decrement function;
  - the index/tag extraction functions.
- One sub-module: rv_bp_sat_counter, a PERF_W saturating event counter, instantiated twice for the perf counters.

Test Plan:
- Reset, then lookup PC_if=0x0000_0040 -> pred_taken=0, pred_target=0x0000_0044, perf_lookups=0.
- update_en with PC=0x40, taken, branch, target=0x80; next cycle lookup 0x40 -> pred_taken=1, pred_target=0x0000_0080.
- Two further not-taken updates on 0x40 (ctr 10 -> 01 -> 00) -> pred_taken=0. Three taken updates -> ctr=11. A fourth taken update -> ctr stays 11.
- Alias test, ENTRIES=64: allocate 0x40, then allocate 0x40+0x100 (same idx, different tag) -> lookup 0x40 misses; lookup 0x140 hits.
- Same-cycle lookup and update on one idx -> the current cycle shows old contents; the next cycle shows new contents. reset+update_en together -> the table stays empty.
- Ten updates with mispredict on alternate ones -> perf_lookups=10, perf_mispredicts=5. With PERF_W=4, twenty updates -> perf_lookups=15 (saturated).

Source files
------------

// File: rtl/rv_bp_pkg.sv
// ---------------------------------------------------------------------------
// rv_bp_pkg
// Shared types and helpers for the RV32I branch predictor.
//   - bpCtr_e     : 2-bit direction counter encodings
//   - bpEntry_t   : one branch-target-buffer entry
//   - satUpdate   : saturating increment/decrement of a direction counter
//   - getIdx      : table index PC[idxW+1:2], zero-extended to 32 bits
//   - getTag      : tag PC[tagW+idxW+1:idxW+2], zero-extended to 32 bits
// ---------------------------------------------------------------------------
package rv_bp_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bpCtr_e;

   // Widest tag that still fits above the smallest index (4 entries) and
   // the two alignment bits. Narrower tags are stored zero-extended so the
   // upper bits never toggle.
   localparam int MAX_TAG_W = 28;

   typedef struct packed {
      logic                 valid;
      logic [MAX_TAG_W-1:0] tag;
      logic                 jump;
      logic [1:0]           ctr;
      logic [29:0]          target;
   } bpEntry_t;

   localparam bpEntry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, jump: 1'b0,
                                        ctr: WNT, target: '0};

   // Move a direction counter one step toward taken or not-taken,
   // holding at the strong ends.
   function automatic logic [1:0] satUpdate(input logic [1:0] ctr, input logic taken);
      logic [1:0] res;
      res = ctr;
      if (taken) begin
         if (ctr != ST) res = ctr + 2'd1;
      end else begin
         if (ctr != SNT) res = ctr - 2'd1;
      end
      return res;
   endfunction

   function automatic logic [31:0] getIdx(input logic [31:0] pc, input int idxW);
      return (pc >> 2) & ((32'd1 << idxW) - 32'd1);
   endfunction

   function automatic logic [31:0] getTag(input logic [31:0] pc, input int idxW, input int tagW);
      return (pc >> (idxW + 2)) & ((32'd1 << tagW) - 32'd1);
   endfunction

endpackage

// File: rtl/rv_bp_sat_counter.sv
// ---------------------------------------------------------------------------
// rv_bp_sat_counter
// W-bit event counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high clear
//   inc   : count one event this cycle
//   count : current count
// ---------------------------------------------------------------------------
module rv_bp_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count events until the counter is full, then hold so software reading
   // the counter sees a clearly saturated value rather than a wrapped one.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/rv_branch_predictor.sv
// ---------------------------------------------------------------------------
// rv_branch_predictor
// Branch target buffer with 2-bit direction counters for the 5-stage RV32I
// pipeline. Lookup is combinational from the IF PC; updates arrive from ID
// and take effect at the next clock edge.
// Optional feature macro: RV_BP_GSHARE_EN (gshare-indexed direction
// counters with a global history register).
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   PC_if              : fetch PC to look up
//   pred_taken         : redirect fetch to pred_target
//   pred_target        : predicted next PC (PC_if+4 on a miss)
//   pred_hist          : history snapshot carried down the pipe
//   update_*           : resolved control transfer from ID
//   perf_lookups       : saturating count of update_en pulses
//   perf_mispredicts   : saturating count of mispredicted updates
// ---------------------------------------------------------------------------
module rv_branch_predictor
   import rv_bp_pkg::*;
#(
   parameter int ENTRIES = 64,
   parameter int TAG_W   = 8,
   parameter int HIST_W  = 6,
   parameter int PERF_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       PC_if,
   output logic              pred_taken,
   output logic [31:0]       pred_target,
   output logic [HIST_W-1:0] pred_hist,
   input  logic              update_en,
   input  logic [31:0]       update_pc,
   input  logic              update_taken,
   input  logic              update_jump,
   input  logic [31:0]       update_target,
   input  logic [HIST_W-1:0] update_hist,
   input  logic              update_mispredict,
   output logic [PERF_W-1:0] perf_lookups,
   output logic [PERF_W-1:0] perf_mispredicts
);

   localparam int IDX_W = $clog2(ENTRIES);

   bpEntry_t btb [ENTRIES];

   logic [IDX_W-1:0]     lookupIdx;
   logic [IDX_W-1:0]     updIdx;
   logic [MAX_TAG_W-1:0] lookupTag;
   logic [MAX_TAG_W-1:0] updTag;
   bpEntry_t             lookupEntry;
   bpEntry_t             updEntry;
   bpEntry_t             newEntry;
   logic [1:0]           lookupCtr;
   logic [1:0]           updCtr;
   logic [1:0]           newCtr;
   logic                 lookupHit;
   logic                 updHit;
   logic                 updAligned;
   logic                 entryWrite;
   logic                 unusedBits;

   assign lookupIdx   = IDX_W'(getIdx(PC_if, IDX_W));
   assign lookupTag   = MAX_TAG_W'(getTag(PC_if, IDX_W, TAG_W));
   assign updIdx      = IDX_W'(getIdx(update_pc, IDX_W));
   assign updTag      = MAX_TAG_W'(getTag(update_pc, IDX_W, TAG_W));
   assign lookupEntry = btb[lookupIdx];
   assign updEntry    = btb[updIdx];
   assign updAligned  = (update_pc[1:0] == 2'b00);

`ifdef RV_BP_GSHARE_EN
   logic [HIST_W-1:0] ghr;
   logic [1:0]        ctrArr [ENTRIES];
   logic [IDX_W-1:0]  lookupCtrIdx;
   logic [IDX_W-1:0]  updCtrIdx;

   // Counters are hashed with history; the update uses the history the
   // instruction saw at fetch so it trains the same counter it read.
   assign lookupCtrIdx = lookupIdx ^ IDX_W'(ghr);
   assign updCtrIdx    = updIdx ^ IDX_W'(update_hist);
   assign lookupCtr    = ctrArr[lookupCtrIdx];
   assign updCtr       = ctrArr[updCtrIdx];
   assign pred_hist    = ghr;
   assign unusedBits   = ^update_target[1:0];

   // Direction counters and global history. Only conditional branches feed
   // the history; jumps are always taken and would just dilute it.
   always_ff @(posedge clk) begin
      if (reset) begin
         ghr <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            ctrArr[i] <= WNT;
         end
      end else begin
         if (entryWrite) begin
            ctrArr[updCtrIdx] <= newCtr;
         end
         if (update_en && updAligned && !update_jump) begin
            ghr <= (ghr << 1) | HIST_W'(update_taken);
         end
      end
   end
`else
   assign lookupCtr  = lookupEntry.ctr;
   assign updCtr     = updEntry.ctr;
   assign pred_hist  = '0;
   assign unusedBits = ^{update_hist, update_target[1:0]};
`endif

   // Lookup sees the table as it stood at the last edge, so an update to
   // the same entry in this cycle is not visible until the next one.
   assign lookupHit   = lookupEntry.valid && (lookupEntry.tag == lookupTag);
   assign pred_taken  = lookupHit && (lookupEntry.jump || lookupCtr[1]);
   assign pred_target = lookupHit ? {lookupEntry.target, 2'b00} : (PC_if + 32'd4);

   assign updHit = updEntry.valid && (updEntry.tag == updTag);

   // Work out the replacement entry and counter for the instruction being
   // resolved. A hit trains the existing entry; a taken miss evicts the
   // occupant and starts the new branch weakly taken (jumps strongly).
   // A not-taken miss is not worth a slot, and misaligned PCs are bogus.
   always_comb begin
      newEntry   = updEntry;
      newCtr     = updCtr;
      entryWrite = 1'b0;
      if (update_en && updAligned) begin
         if (updHit) begin
            entryWrite    = 1'b1;
            newEntry.jump = update_jump;
            newCtr        = update_jump ? ST : satUpdate(updCtr, update_taken);
            if (update_taken) begin
               newEntry.target = update_target[31:2];
            end
         end else if (update_taken) begin
            entryWrite      = 1'b1;
            newEntry.valid  = 1'b1;
            newEntry.tag    = updTag;
            newEntry.jump   = update_jump;
            newEntry.target = update_target[31:2];
            newCtr          = update_jump ? ST : WT;
         end
      end
      newEntry.ctr = newCtr;
   end

   // Table storage. Reset empties every entry in a single cycle and takes
   // priority over any update presented alongside it.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            btb[i] <= RESET_ENTRY;
         end
      end else if (entryWrite) begin
         btb[updIdx] <= newEntry;
      end
   end

   rv_bp_sat_counter #(.W(PERF_W)) lookupCounter (
      .clk   (clk),
      .reset (reset),
      .inc   (update_en),
      .count (perf_lookups)
   );

   rv_bp_sat_counter #(.W(PERF_W)) mispredictCounter (
      .clk   (clk),
      .reset (reset),
      .inc   (update_en && update_mispredict),
      .count (perf_mispredicts)
   );

endmodule
